dlsc_axi_decerr_slave: RTL and testbench

AXI responder that terminates every transaction the interconnect's address decoder fails to match to any range. It sits on the interconnect's default-route port and completes each burst with the full AXI handshake and a DECERR response, so an unmatched address never hangs a master. The read and write channels are independent and each holds at most one transaction in flight.

---
 rtl/dlsc_axi_decerr_slave.sv | 149 ++++++++++++++
 tb/tb_dlsc_axi_decerr_slave.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlsc_axi_decerr_slave.sv
// Default-route AXI slave: every read and write burst is completed with the
// full handshake and a DECERR response; write data is discarded.
module dlsc_axi_decerr_slave #(
    parameter int DATA = 32,
    parameter int ID   = 4,
    parameter int LEN  = 4
) (
    input  logic            clk,
    input  logic            rst_n,

    output logic            axi_ar_ready,
    input  logic            axi_ar_valid,
    input  logic [ID-1:0]   axi_ar_id,
    input  logic [LEN-1:0]  axi_ar_len,

    input  logic            axi_r_ready,
    output logic            axi_r_valid,
    output logic            axi_r_last,
    output logic [ID-1:0]   axi_r_id,
    output logic [DATA-1:0] axi_r_data,
    output logic [1:0]      axi_r_resp,

    output logic            axi_aw_ready,
    input  logic            axi_aw_valid,
    input  logic [ID-1:0]   axi_aw_id,
    input  logic [LEN-1:0]  axi_aw_len,

    output logic            axi_w_ready,
    input  logic            axi_w_valid,
    input  logic            axi_w_last,

    input  logic            axi_b_ready,
    output logic            axi_b_valid,
    output logic [ID-1:0]   axi_b_id,
    output logic [1:0]      axi_b_resp,

    output logic            wlast_err
);

    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic       {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    r_state_t       r_state, r_next;
    w_state_t       w_state, w_next;
    logic [ID-1:0]  r_id, w_id;
    logic [LEN-1:0] r_len, r_count, w_len, w_count;
    logic           ready_en;
    logic           ar_hs, r_hs, aw_hs, w_hs, b_hs, w_final;

    assign ar_hs   = axi_ar_valid && axi_ar_ready;
    assign r_hs    = axi_r_valid  && axi_r_ready;
    assign aw_hs   = axi_aw_valid && axi_aw_ready;
    assign w_hs    = axi_w_valid  && axi_w_ready;
    assign b_hs    = axi_b_valid  && axi_b_ready;
    assign w_final = (w_count == w_len);

    // Holds both address readies low through reset and releases them on the
    // first clock edge afterwards, so no address is taken while rst_n is low.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // ---------------- read channel ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // NOTE: defaulting r_next before the case keeps this purely combinational (no latch).
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)              r_next = R_DATA;
            R_DATA:  if (r_hs && axi_r_last) r_next = R_IDLE;
            default:                         r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id    <= '0;
            r_len   <= '0;
            r_count <= '0;
        end else if (ar_hs) begin
            r_id    <= axi_ar_id;
            r_len   <= axi_ar_len;
            r_count <= '0;
        end else if (r_hs && !axi_r_last) begin
            r_count <= r_count + 1'b1;
        end
    end

    always_comb begin
        axi_ar_ready = ready_en && (r_state == R_IDLE);
        axi_r_valid  = (r_state == R_DATA);
        axi_r_last   = (r_state == R_DATA) && (r_count == r_len);
        axi_r_id     = r_id;
        axi_r_data   = '0;
        axi_r_resp   = (r_state == R_DATA) ? DECERR : 2'b00;
    end

    // ---------------- write channel ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    // Burst end is decided by the beat count alone; axi_w_last is only audited.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs)            w_next = W_DATA;
            W_DATA:  if (w_hs && w_final)  w_next = W_RESP;
            W_RESP:  if (b_hs)             w_next = W_IDLE;
            default:                       w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_id      <= '0;
            w_len     <= '0;
            w_count   <= '0;
            wlast_err <= 1'b0;
        end else begin
            wlast_err <= w_hs && (axi_w_last != w_final);
            if (aw_hs) begin
                w_id    <= axi_aw_id;
                w_len   <= axi_aw_len;
                w_count <= '0;
            end else if (w_hs && !w_final) begin
                w_count <= w_count + 1'b1;
            end
        end
    end

    always_comb begin
        axi_aw_ready = ready_en && (w_state == W_IDLE);
        axi_w_ready  = (w_state == W_DATA);
        axi_b_valid  = (w_state == W_RESP);
        axi_b_id     = w_id;
        axi_b_resp   = (w_state == W_RESP) ? DECERR : 2'b00;
    end

endmodule

// File: tb/tb_dlsc_axi_decerr_slave.sv
// Bench for dlsc_axi_decerr_slave: table of read/write bursts checked through
// R/B scoreboards, plus hand-written reset and concurrency sequences.
module tb_dlsc_axi_decerr_slave;

    localparam int DATA = 32;
    localparam int ID   = 4;
    localparam int LEN  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            axi_ar_ready, axi_ar_valid;
    logic [ID-1:0]   axi_ar_id;
    logic [LEN-1:0]  axi_ar_len;
    logic            axi_r_ready, axi_r_valid, axi_r_last;
    logic [ID-1:0]   axi_r_id;
    logic [DATA-1:0] axi_r_data;
    logic [1:0]      axi_r_resp;
    logic            axi_aw_ready, axi_aw_valid;
    logic [ID-1:0]   axi_aw_id;
    logic [LEN-1:0]  axi_aw_len;
    logic            axi_w_ready, axi_w_valid, axi_w_last;
    logic            axi_b_ready, axi_b_valid;
    logic [ID-1:0]   axi_b_id;
    logic [1:0]      axi_b_resp;
    logic            wlast_err;

    dlsc_axi_decerr_slave #(.DATA(DATA), .ID(ID), .LEN(LEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .axi_ar_ready(axi_ar_ready), .axi_ar_valid(axi_ar_valid),
        .axi_ar_id(axi_ar_id), .axi_ar_len(axi_ar_len),
        .axi_r_ready(axi_r_ready), .axi_r_valid(axi_r_valid), .axi_r_last(axi_r_last),
        .axi_r_id(axi_r_id), .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp),
        .axi_aw_ready(axi_aw_ready), .axi_aw_valid(axi_aw_valid),
        .axi_aw_id(axi_aw_id), .axi_aw_len(axi_aw_len),
        .axi_w_ready(axi_w_ready), .axi_w_valid(axi_w_valid), .axi_w_last(axi_w_last),
        .axi_b_ready(axi_b_ready), .axi_b_valid(axi_b_valid),
        .axi_b_id(axi_b_id), .axi_b_resp(axi_b_resp),
        .wlast_err(wlast_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ID-1:0] id;
        logic          last;
    } rexp_t;

    typedef struct {
        bit            is_wr;
        logic [ID-1:0] id;
        int            len;
        bit            rand_rdy;
        int            extra_last;  // beat index that also asserts w_last, -1 for none
        bit            w_early;
        int            b_stall;
        int            exp_err;     // expected wlast_err pulses
    } vec_t;

    rexp_t         rq[$];
    logic [ID-1:0] bq[$];
    int            checks = 0;
    int            errors = 0;
    int            err_seen = 0;
    vec_t          vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: handshakes are judged at the negedge, where inputs and outputs are both settled.
    logic          r_stalled = 1'b0;
    logic [ID-1:0] r_hold_id;
    logic          r_hold_last;
    always @(negedge clk) begin
        rexp_t e;
        if (rst_n) begin
            if (axi_r_valid && axi_r_ready) begin
                if (rq.size() == 0) fail_now("unexpected R beat");
                else begin
                    e = rq.pop_front();
                    check("r_id",   64'(axi_r_id),   64'(e.id));
                    check("r_last", 64'(axi_r_last), 64'(e.last));
                    check("r_data", 64'(axi_r_data), 64'd0);
                    check("r_resp", 64'(axi_r_resp), 64'd3);
                end
            end
            if (r_stalled) begin
                check("r_valid held", 64'(axi_r_valid), 64'd1);
                check("r_id stable",  64'(axi_r_id),    64'(r_hold_id));
                check("r_last stable", 64'(axi_r_last), 64'(r_hold_last));
            end
            r_stalled   = axi_r_valid && !axi_r_ready;
            r_hold_id   = axi_r_id;
            r_hold_last = axi_r_last;
            if (axi_b_valid && axi_b_ready) begin
                if (bq.size() == 0) fail_now("unexpected B beat");
                else begin
                    check("b_id",   64'(axi_b_id),   64'(bq.pop_front()));
                    check("b_resp", 64'(axi_b_resp), 64'd3);
                end
            end
            if (wlast_err) err_seen++;
        end else begin
            r_stalled = 1'b0;
        end
    end

    task automatic do_read(input logic [ID-1:0] id, input int len, input bit rnd);
        int n;
        for (int b = 0; b <= len; b++) rq.push_back('{id: id, last: (b == len)});
        axi_ar_valid = 1'b1;
        axi_ar_id    = id;
        axi_ar_len   = LEN'(len);
        n = 0;
        while (!axi_ar_ready && n < 50) begin cycle(); n++; end
        if (n >= 50) fail_now("ar_ready timeout");
        cycle();
        axi_ar_valid = 1'b0;
        check("r_valid after AR", 64'(axi_r_valid), 64'd1);
        n = 0;
        while (rq.size() != 0 && n < 3000) begin
            axi_r_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            n++;
        end
        axi_r_ready = 1'b0;
        if (n >= 3000) begin
            fail_now("R burst timeout");
            rq.delete();
        end
        check("ar_ready after burst", 64'(axi_ar_ready), 64'd1);
        check("r_valid after burst",  64'(axi_r_valid),  64'd0);
    endtask

    task automatic do_write(input vec_t v);
        int n;
        int e0;
        e0 = err_seen;
        if (v.w_early) begin
            axi_w_valid = 1'b1;
            axi_w_last  = 1'b0;
            repeat (3) begin
                cycle();
                check("w_ready before AW", 64'(axi_w_ready), 64'd0);
            end
        end
        bq.push_back(v.id);
        axi_aw_valid = 1'b1;
        axi_aw_id    = v.id;
        axi_aw_len   = LEN'(v.len);
        n = 0;
        while (!axi_aw_ready && n < 50) begin cycle(); n++; end
        if (n >= 50) fail_now("aw_ready timeout");
        cycle();
        axi_aw_valid = 1'b0;
        for (int b = 0; b <= v.len; b++) begin
            axi_w_valid = 1'b1;
            axi_w_last  = (b == v.len) || (b == v.extra_last);
            n = 0;
            while (!axi_w_ready && n < 50) begin cycle(); n++; end
            if (n >= 50) begin
                fail_now("w_ready timeout");
                break;
            end
            cycle();
        end
        axi_w_valid = 1'b0;
        axi_w_last  = 1'b0;
        check("w_ready after last beat", 64'(axi_w_ready), 64'd0);
        check("b_valid after last beat", 64'(axi_b_valid), 64'd1);
        axi_b_ready = 1'b0;
        repeat (v.b_stall) begin
            cycle();
            check("b_valid held while stalled", 64'(axi_b_valid), 64'd1);
        end
        axi_b_ready = 1'b1;
        n = 0;
        while (bq.size() != 0 && n < 50) begin cycle(); n++; end
        axi_b_ready = 1'b0;
        if (n >= 50) begin
            fail_now("B timeout");
            bq.delete();
        end
        check("aw_ready after B", 64'(axi_aw_ready), 64'd1);
        check("b_valid after B",  64'(axi_b_valid),  64'd0);
        check("wlast_err pulses", 64'(err_seen - e0), 64'(v.exp_err));
    endtask

    initial begin
        rst_n = 1'b0;
        axi_ar_valid = 1'b0; axi_ar_id = '0; axi_ar_len = '0;
        axi_r_ready  = 1'b0;
        axi_aw_valid = 1'b0; axi_aw_id = '0; axi_aw_len = '0;
        axi_w_valid  = 1'b0; axi_w_last = 1'b0;
        axi_b_ready  = 1'b0;

        //             is_wr id     len  rand extra early stall err
        vecs[0] = '{1'b0, 4'd3,   0, 1'b0,  -1, 1'b0, 0, 0};
        vecs[1] = '{1'b0, 4'd9,   7, 1'b1,  -1, 1'b0, 0, 0};
        vecs[2] = '{1'b1, 4'd5,   3, 1'b0,  -1, 1'b1, 5, 0};
        vecs[3] = '{1'b1, 4'd2,   2, 1'b0,   1, 1'b0, 0, 1};
        vecs[4] = '{1'b1, 4'd7, 255, 1'b0,  -1, 1'b0, 0, 0};
        vecs[5] = '{1'b0, 4'd14, 255, 1'b1, -1, 1'b0, 0, 0};

        repeat (3) cycle();
        check("reset ar_ready",  64'(axi_ar_ready), 64'd0);
        check("reset aw_ready",  64'(axi_aw_ready), 64'd0);
        check("reset r_valid",   64'(axi_r_valid),  64'd0);
        check("reset w_ready",   64'(axi_w_ready),  64'd0);
        check("reset b_valid",   64'(axi_b_valid),  64'd0);
        check("reset wlast_err", 64'(wlast_err),    64'd0);
        rst_n = 1'b1;
        #1;
        check("ar_ready before first edge", 64'(axi_ar_ready), 64'd0);
        cycle();
        check("ar_ready after first edge", 64'(axi_ar_ready), 64'd1);
        check("aw_ready after first edge", 64'(axi_aw_ready), 64'd1);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i]);
            else               do_read(vecs[i].id, vecs[i].len, vecs[i].rand_rdy);
            cycle();
        end

        // Simultaneous AR and AW, one beat on each, then reset mid-burst.
        rq.push_back('{id: 4'hA, last: 1'b0});
        check("ar_ready before dual", 64'(axi_ar_ready), 64'd1);
        check("aw_ready before dual", 64'(axi_aw_ready), 64'd1);
        axi_ar_valid = 1'b1; axi_ar_id = 4'hA; axi_ar_len = 8'd3;
        axi_aw_valid = 1'b1; axi_aw_id = 4'hB; axi_aw_len = 8'd1;
        cycle();
        axi_ar_valid = 1'b0;
        axi_aw_valid = 1'b0;
        check("dual ar_ready low", 64'(axi_ar_ready), 64'd0);
        check("dual aw_ready low", 64'(axi_aw_ready), 64'd0);
        check("dual r_valid",      64'(axi_r_valid),  64'd1);
        check("dual w_ready",      64'(axi_w_ready),  64'd1);
        axi_r_ready = 1'b1;
        axi_w_valid = 1'b1;
        axi_w_last  = 1'b0;
        cycle();
        axi_r_ready = 1'b0;
        axi_w_valid = 1'b0;
        check("dual R beat seen",   64'(rq.size()),    64'd0);
        check("dual r_valid still", 64'(axi_r_valid),  64'd1);
        check("dual r_last low",    64'(axi_r_last),   64'd0);
        check("dual w_ready still", 64'(axi_w_ready),  64'd1);
        rst_n = 1'b0;
        #1;
        check("mid reset r_valid",  64'(axi_r_valid),  64'd0);
        check("mid reset r_last",   64'(axi_r_last),   64'd0);
        check("mid reset w_ready",  64'(axi_w_ready),  64'd0);
        check("mid reset b_valid",  64'(axi_b_valid),  64'd0);
        check("mid reset ar_ready", 64'(axi_ar_ready), 64'd0);
        check("mid reset aw_ready", 64'(axi_aw_ready), 64'd0);
        cycle();
        rst_n = 1'b1;
        axi_r_ready = 1'b1;
        axi_b_ready = 1'b1;
        repeat (10) begin
            cycle();
            check("no R after reset", 64'(axi_r_valid), 64'd0);
            check("no B after reset", 64'(axi_b_valid), 64'd0);
        end
        axi_r_ready = 1'b0;
        axi_b_ready = 1'b0;

        do_read(4'd4, 1, 1'b0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute guard against a hung handshake loop.
    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "global timeout");
    end

endmodule
